// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - sequenced power-on / button / trap reset generator
module reset_sequencer #(
    parameter int HOLD_CYCLES = 65535,
    parameter int DEB_CYCLES  = 50000,
    parameter int TRAP_RST_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_in,
    input  logic       trap_in,
    output logic       sys_rst,
    output logic       rst_done,
    output logic [1:0] rst_cause
);

    // Counters only ever need to reach CYCLES-1; a 1-cycle debounce still needs a 1-bit counter.
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_TRAP = 2'd2;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;

    logic              btn_meta;
    logic              btn_s;
    logic              trap_meta;
    logic              trap_s;

    logic [DEB_W-1:0]  deb_cnt;
    logic              btn_deb;
    logic              btn_deb_q;
    logic              btn_rise;
    logic              btn_fall;

    // Two-flop synchronisers: both asynchronous inputs are only used after this stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
            trap_meta <= 1'b0;
            trap_s    <= 1'b0;
        end else begin
            btn_meta  <= btn_in;
            btn_s     <= btn_meta;
            trap_meta <= trap_in;
            trap_s    <= trap_meta;
        end
    end

    // Debounce: accept a new button level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt   <= '0;
            btn_deb   <= 1'b0;
            btn_deb_q <= 1'b0;
        end else begin
            btn_deb_q <= btn_deb;
            if (btn_s != btn_deb) begin
                if (deb_cnt == DEB_LAST) begin
                    btn_deb <= btn_s;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Edge pulses last exactly one cycle, between the debounced update and its delayed copy.
    assign btn_rise = btn_deb & ~btn_deb_q;
    assign btn_fall = ~btn_deb & btn_deb_q;

    // Sequencer: HOLD counts out the stretch, RUN releases the system, WAIT_REL parks until the button is let go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            sys_rst   <= 1'b1;
            rst_done  <= 1'b0;
            rst_cause <= CAUSE_POR;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (btn_rise) begin
                        // A press restarts the whole sequence once it is released.
                        state     <= ST_WAIT_REL;
                        hold_cnt  <= '0;
                        rst_cause <= CAUSE_BTN;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_RUN;
                        hold_cnt <= '0;
                        sys_rst  <= 1'b0;
                        rst_done <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                ST_RUN: begin
                    if (btn_rise) begin
                        // Button wins over a simultaneous trap.
                        state     <= ST_WAIT_REL;
                        sys_rst   <= 1'b1;
                        rst_done  <= 1'b0;
                        rst_cause <= CAUSE_BTN;
                    end else if ((TRAP_RST_EN != 0) && trap_s) begin
                        state     <= ST_HOLD;
                        hold_cnt  <= '0;
                        sys_rst   <= 1'b1;
                        rst_done  <= 1'b0;
                        rst_cause <= CAUSE_TRAP;
                    end
                end

                ST_WAIT_REL: begin
                    // Trap is deliberately ignored here; the system is already in reset.
                    if (btn_fall) begin
                        state    <= ST_HOLD;
                        hold_cnt <= '0;
                    end
                end

                default: begin
                    state    <= ST_HOLD;
                    hold_cnt <= '0;
                    sys_rst  <= 1'b1;
                    rst_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
